// File: rtl/master_slave09_source.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | master_slave09_source                                                    |
// | Sends an incrementing value to a slave-sync peer, checks the echo.       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module master_slave09_source #(
  parameter int                 LAT    = 1,
  parameter int                 GAP    = 2,
  parameter logic signed [31:0] OFFSET = 32'sd1,
  parameter logic signed [31:0] STEP   = 32'sd1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clr_err,
  input  logic signed [31:0] sh_in,
  output logic signed [31:0] s_out,
  output logic               s_out_sync,
  output logic               busy,
  output logic               err,
  output logic [15:0]        match_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_WAIT = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  localparam logic [3:0] c_LAT_M1 = 4'(LAT - 1);
  localparam logic [3:0] c_GAP_M1 = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
  localparam bit         c_HAS_GAP = (GAP > 0);

  state_t             r_state;
  logic [3:0]         r_cnt;
  logic signed [31:0] r_val;
  logic signed [31:0] r_s_out;
  logic               r_sync;
  logic               r_err;
  logic [15:0]        r_match_cnt;
  logic signed [31:0] w_expect;
  logic               w_match;

  assign w_expect = r_s_out + OFFSET;
  assign w_match  = (sh_in == w_expect);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_val       <= 32'sd0;
      r_s_out     <= 32'sd0;
      r_sync      <= 1'b0;
      r_err       <= 1'b0;
      r_match_cnt <= 16'd0;
    end else begin
      r_sync <= 1'b0;
      // A mismatch later in this block overrides the clear.
      if (clr_err)
        r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (en) begin
            r_state <= S_SEND;
            r_sync  <= 1'b1;
            r_s_out <= r_val;
          end
        end
        S_SEND: begin
          r_state <= S_WAIT;
          r_cnt   <= c_LAT_M1;
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            if (w_match) begin
              if (r_match_cnt != 16'hFFFF)
                r_match_cnt <= r_match_cnt + 16'd1;
            end else begin
              r_err <= 1'b1;
            end
            r_val <= r_val + STEP;
            if (c_HAS_GAP) begin
              r_state <= S_GAP;
              r_cnt   <= c_GAP_M1;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_GAP: begin
          if (r_cnt == 4'd0)
            r_state <= S_IDLE;
          else
            r_cnt <= r_cnt - 4'd1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign s_out      = r_s_out;
  assign s_out_sync = r_sync;
  assign busy       = (r_state != S_IDLE);
  assign err        = r_err;
  assign match_cnt  = r_match_cnt;

endmodule
`default_nettype wire
